// File: rtl/circle_pkg.sv
// Shared definitions for the circle point sequencer.
// Holds the base_sel encodings, the Q16.16 number format, the controller FSM
// state type and the point payload carried through the output buffer.
package circle_pkg;

    // base_sel encodings
    localparam logic [1:0] BASE_SEL_2    = 2'b00;
    localparam logic [1:0] BASE_SEL_3    = 2'b01;
    localparam logic [1:0] BASE_SEL_7    = 2'b10;
    localparam logic [1:0] BASE_SEL_RSVD = 2'b11;

    // Q16.16 two's complement coordinate format
    localparam int unsigned Q_WIDTH = 32;
    localparam int unsigned Q_FRAC  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_PUSH  = 2'd3
    } state_e;

    typedef struct packed {
        logic [Q_WIDTH-1:0] x;
        logic [Q_WIDTH-1:0] y;
    } point_t;

endpackage

// File: rtl/circle_point_fifo.sv
// First-word-fall-through point buffer.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push_i, din_i     write strobe and entry (dropped if full)
//   pop_i             read strobe (ignored if empty)
//   dout_o, valid_o   head entry and its valid flag
//   level_o           number of stored entries
module circle_point_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             valid_q, valid_d;
    logic             do_push_c, do_pop_c;

    // Next-state: pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        do_push_c = push_i && (level_q != LVL_W'(DEPTH));
        do_pop_c  = pop_i && valid_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        valid_d = (level_d != '0);
    end

    // State and storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q] <= din_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign valid_o = valid_q;
    assign level_o = level_q;

endmodule

// File: rtl/circle_seq_ctrl.sv
// Circle point sequencer: issues indices k = 1, 2, ... to a downstream circle
// core one request at a time and buffers the returned (x, y, k) points.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   enable, base_sel              run request and base select (11 reserved)
//   core_start/core_k/core_base_sel  request to the core
//   core_ready/core_done/core_x/core_y  core status and Q16.16 result
//   out_valid/out_ready/out_x/out_y/out_k  buffered point stream
//   fifo_level, busy              buffer occupancy, FSM not idle
//   seed_valid, seed_k            k_cnt preload (only with CIRCLE_SEQ_SEED_EN)
// Build option: define CIRCLE_SEQ_SEED_EN to add the seed ports.
module circle_seq_ctrl
    import circle_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned K_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [1:0]                  base_sel,
    output logic                        core_start,
    output logic [K_WIDTH-1:0]          core_k,
    output logic [1:0]                  core_base_sel,
    input  logic                        core_ready,
    input  logic                        core_done,
    input  logic [Q_WIDTH-1:0]          core_x,
    input  logic [Q_WIDTH-1:0]          core_y,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [Q_WIDTH-1:0]          out_x,
    output logic [Q_WIDTH-1:0]          out_y,
    output logic [K_WIDTH-1:0]          out_k,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
`ifdef CIRCLE_SEQ_SEED_EN
    input  logic                        seed_valid,
    input  logic [K_WIDTH-1:0]          seed_k,
`endif
    output logic                        busy
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENT_W = 2 * Q_WIDTH + K_WIDTH;

    state_e             state_q, state_d;
    logic [K_WIDTH-1:0] k_cnt_q, k_cnt_d;
    logic               core_start_q, core_start_d;
    logic [K_WIDTH-1:0] core_k_q, core_k_d;
    logic [1:0]         core_base_sel_q, core_base_sel_d;
    point_t             pt_q, pt_d;
    logic [K_WIDTH-1:0] pt_k_q, pt_k_d;
    logic               busy_q, busy_d;
    logic               push_c, pop_c, start_ok_c;
    logic [ENT_W-1:0]   fifo_dout;

    // Issue only when a free buffer slot is guaranteed for the result
    assign start_ok_c = enable && core_ready && (base_sel != BASE_SEL_RSVD)
                        && (fifo_level < LVL_W'(FIFO_DEPTH));

    // Next-state and request/result capture
    always_comb begin
        state_d         = state_q;
        k_cnt_d         = k_cnt_q;
        core_start_d    = 1'b0;
        core_k_d        = core_k_q;
        core_base_sel_d = core_base_sel_q;
        pt_d            = pt_q;
        pt_k_d          = pt_k_q;
        push_c          = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef CIRCLE_SEQ_SEED_EN
                // A seed load takes the cycle; issue resumes with the new k
                if (seed_valid) begin
                    k_cnt_d = (seed_k == '0) ? K_WIDTH'(1) : seed_k;
                end else
`endif
                if (start_ok_c) begin
                    state_d         = ST_ISSUE;
                    core_start_d    = 1'b1;
                    core_k_d        = k_cnt_q;
                    core_base_sel_d = base_sel;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    pt_d.x  = core_x;
                    pt_d.y  = core_y;
                    pt_k_d  = k_cnt_q;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                push_c  = 1'b1;
                // k = 0 is never issued: wrap from all-ones back to 1
                k_cnt_d = (k_cnt_q == {K_WIDTH{1'b1}}) ? K_WIDTH'(1)
                                                       : k_cnt_q + K_WIDTH'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            k_cnt_q         <= K_WIDTH'(1);
            core_start_q    <= 1'b0;
            core_k_q        <= '0;
            core_base_sel_q <= '0;
            pt_q            <= '0;
            pt_k_q          <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            k_cnt_q         <= k_cnt_d;
            core_start_q    <= core_start_d;
            core_k_q        <= core_k_d;
            core_base_sel_q <= core_base_sel_d;
            pt_q            <= pt_d;
            pt_k_q          <= pt_k_d;
            busy_q          <= busy_d;
        end
    end

    assign pop_c = out_valid && out_ready;

    circle_point_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .din_i   ({pt_q.x, pt_q.y, pt_k_q}),
        .pop_i   (pop_c),
        .dout_o  (fifo_dout),
        .valid_o (out_valid),
        .level_o (fifo_level)
    );

    assign {out_x, out_y, out_k} = fifo_dout;
    assign core_start    = core_start_q;
    assign core_k        = core_k_q;
    assign core_base_sel = core_base_sel_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_circle_seq_ctrl.sv
// Directed bench for circle_seq_ctrl with a behavioural circle core.
module tb_circle_seq_ctrl;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned K_WIDTH    = 32;
    localparam real         PI         = 3.14159265358979323846;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        enable;
    logic [1:0]                  base_sel;
    logic                        core_start;
    logic [K_WIDTH-1:0]          core_k;
    logic [1:0]                  core_base_sel;
    logic                        core_ready;
    logic                        core_done;
    logic [31:0]                 core_x = '0;
    logic [31:0]                 core_y = '0;
    logic                        out_valid;
    logic                        out_ready;
    logic [31:0]                 out_x;
    logic [31:0]                 out_y;
    logic [K_WIDTH-1:0]          out_k;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        busy;
`ifdef CIRCLE_SEQ_SEED_EN
    logic                        seed_valid = 1'b0;
    logic [K_WIDTH-1:0]          seed_k     = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    circle_seq_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .K_WIDTH    (K_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .base_sel      (base_sel),
        .core_start    (core_start),
        .core_k        (core_k),
        .core_base_sel (core_base_sel),
        .core_ready    (core_ready),
        .core_done     (core_done),
        .core_x        (core_x),
        .core_y        (core_y),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_k         (out_k),
        .fifo_level    (fifo_level),
`ifdef CIRCLE_SEQ_SEED_EN
        .seed_valid    (seed_valid),
        .seed_k        (seed_k),
`endif
        .busy          (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Radical inverse of k in base b, mapped to a point on the unit circle
    function automatic real radinv(input int unsigned k, input int unsigned b);
        real f = 1.0 / real'(b);
        real r = 0.0;
        int unsigned n = k;
        while (n > 0) begin
            r = r + f * real'(n % b);
            n = n / b;
            f = f / real'(b);
        end
        return r;
    endfunction

    function automatic int unsigned base_of(input logic [1:0] sel);
        case (sel)
            2'b01:   return 3;
            2'b10:   return 7;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] q16(input real v);
        int i;
        if (v >= 0.0) i = $rtoi(v * 65536.0 + 0.5);
        else          i = -$rtoi(-v * 65536.0 + 0.5);
        return 32'(i);
    endfunction

    // Behavioural core: fixed latency, not affected by the controller reset
    logic core_busy = 1'b0;
    logic core_done_q = 1'b0;
    int   core_cnt = 0;
    logic [31:0] pend_x = '0, pend_y = '0;

    assign core_ready = ~core_busy;
    assign core_done  = core_done_q;

    always @(posedge clk) begin
        core_done_q <= 1'b0;
        if (core_busy) begin
            if (core_cnt == 0) begin
                core_done_q <= 1'b1;
                core_x      <= pend_x;
                core_y      <= pend_y;
                core_busy   <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end else if (core_start) begin
            core_busy <= 1'b1;
            core_cnt  <= 2;
            pend_x    <= q16($cos(2.0 * PI * radinv(core_k, base_of(core_base_sel))));
            pend_y    <= q16($sin(2.0 * PI * radinv(core_k, base_of(core_base_sel))));
        end
    end

    // Monitor: record requests and popped points
    logic [K_WIDTH-1:0] st_k[$];
    logic [1:0]         st_b[$];
    logic [K_WIDTH-1:0] ok_q[$];
    logic [31:0]        ox_q[$];
    logic [31:0]        oy_q[$];
    int cyc = 0;
    int first_done = -1;
    int first_valid = -1;

    always @(negedge clk) begin
        cyc++;
        if (core_start) begin
            st_k.push_back(core_k);
            st_b.push_back(core_base_sel);
        end
        if (out_valid && out_ready) begin
            ok_q.push_back(out_k);
            ox_q.push_back(out_x);
            oy_q.push_back(out_y);
        end
        if (core_done && first_done < 0) first_done = cyc;
        if (out_valid && first_valid < 0) first_valid = cyc;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int c = 0;
        while (st_k.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic wait_pops(input int n, input int budget);
        int c = 0;
        while (ok_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic clear_logs();
        st_k.delete();
        st_b.delete();
        ok_q.delete();
        ox_q.delete();
        oy_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        clear_logs();
    endtask

    logic [31:0] exp_x [5] = '{32'hFFFF0000, 32'h00000000, 32'h00000000, 32'h0000B505, 32'hFFFF4AFB};
    logic [31:0] exp_y [5] = '{32'h00000000, 32'h00010000, 32'hFFFF0000, 32'h0000B505, 32'hFFFF4AFB};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        base_sel  = 2'b00;
        out_ready = 1'b0;
        wait_cycles(2);

        // Reset values
        check_eq("rst_core_start", 64'(core_start), 64'd0);
        check_eq("rst_core_k", 64'(core_k), 64'd0);
        check_eq("rst_core_base", 64'(core_base_sel), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_x", 64'(out_x), 64'd0);
        check_eq("rst_out_y", 64'(out_y), 64'd0);
        check_eq("rst_out_k", 64'(out_k), 64'd0);
        check_eq("rst_level", 64'(fifo_level), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        clear_logs();

        // Base 2 sequence, free-running output
        first_done  = -1;
        first_valid = -1;
        @(posedge clk);
        #1 enable = 1'b1; out_ready = 1'b1; base_sel = 2'b00;
        wait_pops(5, 400);
        check_eq("b2_npops", 64'(ok_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("b2_k%0d", i), 64'(ok_q[i]), 64'(i + 1));
            check_eq($sformatf("b2_x%0d", i), 64'(ox_q[i]), 64'(exp_x[i]));
            check_eq($sformatf("b2_y%0d", i), 64'(oy_q[i]), 64'(exp_y[i]));
        end
        check_eq("valid_latency", 64'(first_valid - first_done), 64'd2);
        @(posedge clk);
        #1 enable = 1'b0;

        // Backpressure: buffer fills, then one pop admits one more request
        do_reset();
        @(posedge clk);
        #1 enable = 1'b1; out_ready = 1'b0; base_sel = 2'b10;
        wait_cycles(200);
        check_eq("bp_starts", 64'(st_k.size()), 64'd4);
        check_eq("bp_level", 64'(fifo_level), 64'd4);
        check_eq("bp_busy", 64'(busy), 64'd0);
        check_eq("bp_head_k", 64'(out_k), 64'd1);
        check_eq("bp_base", 64'(st_b[3]), 64'h2);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        wait_cycles(100);
        check_eq("bp_starts2", 64'(st_k.size()), 64'd5);
        check_eq("bp_k5", 64'(st_k[4]), 64'd5);
        check_eq("bp_level2", 64'(fifo_level), 64'd4);
        check_eq("bp_pops", 64'(ok_q.size()), 64'd1);
        check_eq("bp_head_k2", 64'(out_k), 64'd2);
        @(posedge clk);
        #1 enable = 1'b0;

        // Reserved base holds the controller idle
        do_reset();
        @(posedge clk);
        #1 enable = 1'b1; out_ready = 1'b1; base_sel = 2'b11;
        wait_cycles(50);
        check_eq("rsv_starts", 64'(st_k.size()), 64'd0);
        check_eq("rsv_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 base_sel = 2'b01;
        wait_starts(1, 20);
        check_eq("rsv_k", 64'(st_k[0]), 64'd1);
        check_eq("rsv_base", 64'(st_b[0]), 64'h1);
        @(posedge clk);
        #1 base_sel = 2'b11;
        wait_cycles(40);
        check_eq("rsv_pops", 64'(ok_q.size()), 64'd1);
        check_eq("rsv_pop_k", 64'(ok_q[0]), 64'd1);
        check_eq("rsv_starts2", 64'(st_k.size()), 64'd1);
        @(posedge clk);
        #1 enable = 1'b0;

        // Enable dropped while waiting on the core
        do_reset();
        @(posedge clk);
        #1 enable = 1'b1; out_ready = 1'b1; base_sel = 2'b00;
        wait_starts(1, 20);
        @(posedge clk);
        #1 enable = 1'b0;
        wait_cycles(50);
        check_eq("en_starts", 64'(st_k.size()), 64'd1);
        check_eq("en_pops", 64'(ok_q.size()), 64'd1);
        check_eq("en_pop_k", 64'(ok_q[0]), 64'd1);
        check_eq("en_busy", 64'(busy), 64'd0);

        // Reset while waiting on the core
        @(posedge clk);
        #1 enable = 1'b1;
        wait_starts(2, 30);
        check_eq("rw_k2", 64'(st_k[1]), 64'd2);
        @(posedge clk);
        #1 rst = 1'b1; enable = 1'b0;
        #1;
        check_eq("rw_core_start", 64'(core_start), 64'd0);
        check_eq("rw_core_k", 64'(core_k), 64'd0);
        check_eq("rw_busy", 64'(busy), 64'd0);
        check_eq("rw_level", 64'(fifo_level), 64'd0);
        check_eq("rw_out_valid", 64'(out_valid), 64'd0);
        check_eq("rw_out_k", 64'(out_k), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(30);
        check_eq("rw_pops", 64'(ok_q.size()), 64'd1);
        check_eq("rw_level2", 64'(fifo_level), 64'd0);
        check_eq("rw_busy2", 64'(busy), 64'd0);
        clear_logs();
        @(posedge clk);
        #1 enable = 1'b1;
        wait_starts(1, 30);
        check_eq("rw_restart_k", 64'(st_k[0]), 64'd1);
        @(posedge clk);
        #1 enable = 1'b0;
        wait_cycles(20);

`ifdef CIRCLE_SEQ_SEED_EN
        // Seed near the wrap point
        do_reset();
        @(posedge clk);
        #1 seed_valid = 1'b1; seed_k = '1;
        @(posedge clk);
        #1 seed_valid = 1'b0; enable = 1'b1; out_ready = 1'b1; base_sel = 2'b00;
        wait_starts(3, 100);
        check_eq("seed_k0", 64'(st_k[0]), 64'hFFFFFFFF);
        check_eq("seed_k1", 64'(st_k[1]), 64'h1);
        check_eq("seed_k2", 64'(st_k[2]), 64'h2);
        @(posedge clk);
        #1 enable = 1'b0;
        wait_cycles(20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/circle_seq_ctrl.md
CIRCLE_SEQ_CTRL -- requirements
Module: circle_seq_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output point buffer depth (power of two, 2..16).
REQ-002 SHALL have parameter K_WIDTH, default 32, sequence index width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  run request; sequence advances only while high.
REQ-006 SHALL have port base_sel  input  2  base select: 00=2, 01=3, 10=7, 11=reserved.
REQ-007 SHALL have port core_start  output  1  one-cycle start pulse to downstream circle core.
REQ-008 SHALL have port core_k  output  K_WIDTH  index presented with core_start.
REQ-009 SHALL have port core_base_sel  output  2  base presented with core_start.
REQ-010 SHALL have port core_ready  input  1  core idle.
REQ-011 SHALL have port core_done  input  1  core result valid.
REQ-012 SHALL have port core_x / core_y  input  32 each  core result, Q16.16 two's complement.
REQ-013 SHALL have port out_valid / out_ready  output / input  1 each  point stream handshake.
REQ-014 SHALL have port out_x / out_y / out_k  output  32 / 32 / K_WIDTH  buffered point and its index.
REQ-015 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  buffered point count.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL run FSM IDLE -> ISSUE -> WAIT -> PUSH -> IDLE; at most one core request outstanding.
REQ-018 IDLE -> ISSUE SHALL require enable=1, core_ready=1, base_sel!=11, fifo_level<FIFO_DEPTH, all sampled same edge.
REQ-019 ISSUE SHALL assert core_start exactly one cycle, with core_k=k_cnt and core_base_sel equal to the base_sel latched on the IDLE->ISSUE edge.
REQ-020 WAIT SHALL hold until core_done=1, then register core_x, core_y, latched k, and enter PUSH.
REQ-021 PUSH SHALL write {x,y,k} into the FIFO and advance k_cnt; out_valid for that entry SHALL rise 2 cycles after the core_done cycle if the FIFO was empty.
REQ-022 k_cnt SHALL start at 1 and increment by 1; from 2^K_WIDTH-1 it SHALL wrap to 1 (0 never issued).
REQ-023 FIFO SHALL be first-word-fall-through: out_valid = (fifo_level!=0); pop on out_valid&&out_ready.
REQ-024 Simultaneous push and pop SHALL leave fifo_level unchanged; pop on empty / push on full SHALL never occur (REQ-018 guarantees no overflow).
REQ-025 enable falling in ISSUE/WAIT/PUSH SHALL not abort; the request completes and is pushed, then FSM stays IDLE.
REQ-026 base_sel=11 SHALL hold FSM in IDLE with no core_start; base_sel changes after latching SHALL not affect the request in flight.
REQ-027 core_done outside WAIT SHALL be ignored.

Reset
REQ-028 rst SHALL asynchronously force: state=IDLE, k_cnt=1, FIFO empty, core_start=0, core_k=0, core_base_sel=0, out_valid=0, out_x=out_y=out_k=0, fifo_level=0, busy=0.
REQ-029 rst during WAIT SHALL discard the outstanding request; a core_done arriving after reset release with FSM in IDLE SHALL be ignored.

Configuration
REQ-030 With CIRCLE_SEQ_SEED_EN defined, ports seed_valid (input 1) and seed_k (input K_WIDTH) SHALL exist; seed_valid in IDLE loads k_cnt=seed_k (seed_k=0 loads 1); ignored in other states.
REQ-031 Without CIRCLE_SEQ_SEED_EN, seed ports SHALL be absent and k_cnt changes only per REQ-022/REQ-028.

Structure
REQ-032 Package circle_pkg SHALL hold base_sel encodings, Q16.16 width/fraction constants, and the FSM state typedef.
REQ-033 The buffer SHALL be a sub-module circle_point_fifo (parameterised depth/width, async active-high reset).

Verification
REQ-034 Base 00, enable=1, out_ready=1, behavioural core: first 5 outputs k=1..5, x/y = FFFF0000/00000000, 00000000/00010000, 00000000/FFFF0000, 0000B505/0000B505, FFFF4AFB/FFFF4AFB (±0x1000).
REQ-035 out_ready=0, FIFO_DEPTH=4, base 10: exactly 4 core_start pulses, fifo_level=4, no further start; one pop -> exactly one further start.
REQ-036 base_sel=11, enable=1 for 50 cycles -> zero core_start, busy=0; switch to 01 -> core_start with core_k=1, core_base_sel=01.
REQ-037 enable dropped in WAIT -> that point still emerges with k=1, no second core_start; rst pulsed in WAIT -> all outputs at reset values, next start has core_k=1.
REQ-038 CIRCLE_SEQ_SEED_EN, seed_k=FFFFFFFF -> core_k sequence FFFFFFFF, 00000001, 00000002.
